// File: rtl/lib_hndsk_rr_arb.sv
// N-to-1 round-robin arbiter with packet lock feeding one registered valid/ready output stage.
// A requester that wins with a non-last beat holds the output until its last beat transfers.
module lib_hndsk_rr_arb #(
    parameter int N       = 4,
    parameter int D_WIDTH = 16,
    localparam int IDW    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         vldi,
    input  logic [N-1:0]         lasti,
    input  logic [N*D_WIDTH-1:0] datai,
    output logic [N-1:0]         rdyi,
    output logic                 vldo,
    output logic                 lasto,
    output logic [D_WIDTH-1:0]   datao,
    output logic [IDW-1:0]       srco,
    input  logic                 rdyo
);

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]   state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] lock_id;

    logic           acc;
    logic [IDW:0]   pick;
    logic [IDW-1:0] sel;
    logic           sel_en;
    logic           xfer;
    logic           sel_last;
    logic [D_WIDTH-1:0] sel_data;

    // Returns {found, index} of the first requester at or after start, wrapping at N-1.
    function automatic logic [IDW:0] rr_pick(input logic [N-1:0] req, input logic [IDW-1:0] start);
        logic [IDW:0] res;
        int idx;
        res = '0;
        for (int j = 0; j < N; j++) begin
            idx = int'(start) + j;
            if (idx >= N) idx = idx - N;
            if (!res[IDW] && req[idx]) res = {1'b1, IDW'(idx)};
        end
        return res;
    endfunction

    function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] k);
        return (k == IDW'(N - 1)) ? '0 : k + 1'b1;
    endfunction

    assign acc = !vldo || rdyo;

    always_comb begin
        pick   = rr_pick(vldi, ptr);
        sel    = (state == ST_LOCK) ? lock_id : pick[IDW-1:0];
        sel_en = (state == ST_LOCK) || pick[IDW];
        rdyi   = '0;
        if (!rst && sel_en) rdyi[sel] = acc;
    end

    assign xfer     = vldi[sel] && rdyi[sel];
    assign sel_last = lasti[sel];
    assign sel_data = datai[sel*D_WIDTH +: D_WIDTH];

    // Output stage: refilled on any input transfer, emptied when drained with nothing to replace it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vldo    <= 1'b0;
            lasto   <= 1'b0;
            datao   <= '0;
            srco    <= '0;
            ptr     <= '0;
            state   <= ST_ARB;
            lock_id <= '0;
        end else if (acc) begin
            if (xfer) begin
                vldo  <= 1'b1;
                datao <= sel_data;
                lasto <= sel_last;
                srco  <= sel;
                if (sel_last) begin
                    state <= ST_ARB;
                    ptr   <= ptr_after(sel);
                end else begin
                    state   <= ST_LOCK;
                    lock_id <= sel;
                end
            end else begin
                vldo <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lib_hndsk_rr_arb.sv
// Directed bench for lib_hndsk_rr_arb: N=4 instance for most scenarios, N=3 instance for wrap.
module tb_lib_hndsk_rr_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  vldi, lasti, rdyi;
    logic [63:0] datai;
    logic        vldo, lasto, rdyo;
    logic [15:0] datao;
    logic [1:0]  srco;

    logic [2:0]  vldi3, lasti3, rdyi3;
    logic [47:0] datai3;
    logic        vldo3, lasto3, rdyo3;
    logic [15:0] datao3;
    logic [1:0]  srco3;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    lib_hndsk_rr_arb #(.N(4), .D_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .vldi(vldi), .lasti(lasti), .datai(datai), .rdyi(rdyi),
        .vldo(vldo), .lasto(lasto), .datao(datao), .srco(srco), .rdyo(rdyo)
    );

    lib_hndsk_rr_arb #(.N(3), .D_WIDTH(16)) u_dut3 (
        .clk(clk), .rst(rst), .vldi(vldi3), .lasti(lasti3), .datai(datai3), .rdyi(rdyi3),
        .vldo(vldo3), .lasto(lasto3), .datao(datao3), .srco(srco3), .rdyo(rdyo3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        vldi  = '0; lasti = '0; rdyo = 1'b1;
        vldi3 = '0; lasti3 = '0; rdyo3 = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_data(input int i, input logic [15:0] v);
        datai[i*16 +: 16] = v;
    endtask

    initial begin
        datai  = '0;
        datai3 = '0;
        rst    = 1'b1;
        vldi   = 4'b1111; lasti = 4'b1111; rdyo = 1'b1;
        vldi3  = '0; lasti3 = '0; rdyo3 = 1'b1;
        tick();
        #1;
        chk("rst_vldo", vldo, 0);
        chk("rst_srco", srco, 0);
        chk("rst_datao", datao, 0);
        chk("rst_lasto", lasto, 0);
        chk("rst_rdyi", rdyi, 4'b0000);

        // Round robin, single-beat packets
        do_reset();
        for (int i = 0; i < 4; i++) set_data(i, 16'h1000 + 16'(i));
        vldi = 4'b1111; lasti = 4'b1111; rdyo = 1'b1;
        #1;
        chk("rr_rdyi0", rdyi, 4'b0001);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("rr_srco%0d", c), srco, c % 4);
            chk($sformatf("rr_vldo%0d", c), vldo, 1);
            chk($sformatf("rr_data%0d", c), datao, 16'h1000 + (c % 4));
        end

        // Backpressure
        do_reset();
        set_data(1, 16'hA5A5);
        vldi = 4'b0010; lasti = 4'b1111; rdyo = 1'b1;
        tick();
        chk("bp_first_src", srco, 1);
        chk("bp_first_data", datao, 16'hA5A5);
        vldi = 4'b1111; rdyo = 1'b0;
        set_data(1, 16'h5555);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp_rdyi%0d", c), rdyi, 4'b0000);
            tick();
            chk($sformatf("bp_data%0d", c), datao, 16'hA5A5);
            chk($sformatf("bp_src%0d", c), srco, 1);
            chk($sformatf("bp_vldo%0d", c), vldo, 1);
        end
        rdyo = 1'b1;
        #1;
        chk("bp_rdyi_release", rdyi, 4'b0100);
        tick();
        chk("bp_next_src", srco, 2);

        // Packet lock on requester 3 (ptr is now 3)
        vldi = 4'b1011; lasti = 4'b0011;
        set_data(3, 16'h0030);
        #1;
        chk("lk_rdyi0", rdyi, 4'b1000);
        tick();
        chk("lk_src0", srco, 3);
        chk("lk_data0", datao, 16'h0030);
        chk("lk_last0", lasto, 0);
        set_data(3, 16'h0031);
        #1;
        chk("lk_rdyi1", rdyi, 4'b1000);
        tick();
        chk("lk_src1", srco, 3);
        chk("lk_data1", datao, 16'h0031);
        chk("lk_last1", lasto, 0);
        set_data(3, 16'h0032);
        lasti = 4'b1011;
        tick();
        chk("lk_src2", srco, 3);
        chk("lk_data2", datao, 16'h0032);
        chk("lk_last2", lasto, 1);
        vldi = 4'b0011;
        #1;
        chk("lk_rdyi_after", rdyi, 4'b0001);
        tick();
        chk("lk_next_src", srco, 0);

        // Lock with a gap on requester 1
        do_reset();
        set_data(1, 16'h0100);
        vldi = 4'b0010; lasti = 4'b0000; rdyo = 1'b1;
        tick();
        chk("gap_src0", srco, 1);
        chk("gap_last0", lasto, 0);
        vldi = 4'b0001; lasti = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("gap_rdyi%0d", c), rdyi, 4'b0010);
            tick();
            chk($sformatf("gap_vldo%0d", c), vldo, 0);
        end
        vldi = 4'b0011; lasti = 4'b0011;
        set_data(1, 16'h0101);
        #1;
        chk("gap_rdyi_last", rdyi, 4'b0010);
        tick();
        chk("gap_src_last", srco, 1);
        chk("gap_lasto", lasto, 1);
        chk("gap_data_last", datao, 16'h0101);
        vldi = 4'b0101; lasti = 4'b0101;
        #1;
        chk("gap_rdyi_next", rdyi, 4'b0100);
        tick();
        chk("gap_next_src", srco, 2);

        // Reset while locked on requester 2
        do_reset();
        vldi = 4'b0100; lasti = 4'b0000; rdyo = 1'b1;
        tick();
        chk("mr_src_pre", srco, 2);
        chk("mr_vldo_pre", vldo, 1);
        rst = 1'b1;
        #1;
        chk("mr_vldo", vldo, 0);
        chk("mr_srco", srco, 0);
        chk("mr_rdyi", rdyi, 4'b0000);
        tick();
        rst = 1'b0;
        vldi = 4'b0001; lasti = 4'b0001;
        #1;
        chk("mr_rdyi_after", rdyi, 4'b0001);
        tick();
        chk("mr_vldo_after", vldo, 1);
        chk("mr_srco_after", srco, 0);

        // N=3 pointer wrap
        do_reset();
        for (int i = 0; i < 3; i++) datai3[i*16 +: 16] = 16'h3000 + 16'(i);
        vldi3 = 3'b111; lasti3 = 3'b111; rdyo3 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("n3_src%0d", c), srco3, c % 3);
            chk($sformatf("n3_data%0d", c), datao3, 16'h3000 + (c % 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lib_hndsk_rr_arb.md
Name: lib_hndsk_rr_arb

Overview:
- N-to-1 round-robin arbiter that shares a single registered valid/ready output stage between N valid/ready requesters.
- Supports packet lock: once a requester wins with a non-last beat, it keeps the output until its last beat transfers.
- Sits in front of any shared downstream consumer (memory port, bus bridge) that accepts one valid/ready stream.
- Output is fully registered: vldo, datao, lasto and srco all come from flops.

Parameters:
- N, 4: number of requesters, 2..16.
- D_WIDTH, 16: data width per requester.
- IDW (localparam), $clog2(N): width of the source-id field.

Ports:
- clk  input  1  clock; all flops update on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- vldi  input  N  per-requester valid.
- lasti  input  N  per-requester last-beat-of-packet flag; sampled only with vldi.
- datai  input  N*D_WIDTH  packed data; requester i occupies bits [i*D_WIDTH +: D_WIDTH].
- rdyi  output  N  per-requester ready; one-hot or zero.
- vldo  output  1  output valid.
- lasto  output  1  last flag of the beat currently on the output.
- datao  output  D_WIDTH  output data.
- srco  output  IDW  index of the requester that sourced the beat on the output.
- rdyo  input  1  downstream ready.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: vldo=0, lasto=0, datao=0, srco=0, pointer ptr=0, state=ARB, lock id=0.
- rdyi is 0 while rst is high.
- Transfers:
  - Input transfer on requester i when vldi[i] && rdyi[i].
  - Output transfer when vldo && rdyo.
- Slot-free term: acc = !vldo || rdyo. This is combinational from rdyo; there is no combinational path from vldi to rdyo.
- State ARB:
  - Winner w is the first i with vldi[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
  - rdyi[w] = acc; every other rdyi bit is 0.
  - rdyi depends combinationally on vldi and rdyo.
- State LOCKED(id):
  - rdyi[id] = acc; all other bits are 0.
  - Other requesters are ignored regardless of vldi.
- Register update when acc=1 and a requester k transfers (k = w in ARB, k = id in LOCKED):
  - datao <= datai[k], lasto <= lasti[k], srco <= k, vldo <= 1.
  - If lasti[k]=1: state <= ARB, ptr <= (k+1) mod N.
  - If lasti[k]=0: state <= LOCKED(k), ptr unchanged.
- acc=1 with no input transfer: vldo <= 0. datao, lasto and srco hold their values; state and ptr are unchanged.
- acc=0: all registers hold. The output beat stays stable until consumed (valid/ready rule: no retraction, no data change while vldo && !rdyo).
- Latency:
  - One cycle from input transfer to vldo.
  - Full throughput: one beat per cycle with rdyo held at 1, including back-to-back beats from different requesters.
- Single-beat packets (lasti=1) give pure round-robin. Each winner becomes lowest priority next time.
- ptr advances only on a completed packet. It is never advanced by idle cycles.
- Simultaneous events:
  - Output drain and new input transfer in the same cycle replace the slot with no bubble.
  - A lock-holder dropping vldi mid-packet keeps the lock (vldo goes 0 after drain) until its last beat arrives.
- N not a power of two: ptr wrap uses an explicit compare to N-1, never bit truncation. srco never exceeds N-1.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). Any in-flight beat and any lock are dropped. No output transfer occurs in the reset cycle.

Test Plan:
- Reset: assert rst mid-packet while LOCKED(2) with vldo=1 -> vldo=0, srco=0, rdyi=0 immediately; after release with vldi=4'b0001, lasti=1 -> rdyi=4'b0001, then vldo=1, srco=0.
- Round-robin fairness: vldi=4'b1111 held, all lasti=1, rdyo=1, N=4 -> srco sequence 0,1,2,3,0,1 on consecutive cycles; vldo=1 continuously from the second cycle.
- Backpressure: rdyo=0 after the first beat (datao=16'hA5A5, srco=1) for 5 cycles while vldi=4'b1111 -> rdyi=0 throughout; datao/srco/vldo stable; on rdyo=1 the next winner is srco=2.
- Packet lock: requester 3 sends 3 beats (lasti=0,0,1, data 16'h0030..16'h0032) while requesters 0 and 1 are valid -> srco=3 for three beats, lasto=1 on the third; next grant goes to srco=0 (ptr wrapped to 0).
- Lock with gap: requester 1 sends a non-last beat, drops vldi 3 cycles while requester 0 is valid, then sends its last beat -> rdyi[0] stays 0 during the gap; vldo=0 during the gap after drain; next grant after the last beat is requester 2 if valid, else requester 0.
- N=3 wrap: vldi=3'b111, lasti=1 -> srco sequence 0,1,2,0; srco never equals 3.
